redirect_ctrl: RTL and testbench
================================

REDIRECT_CTRL -- requirements
Module: redirect_ctrl

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 3: the maximum number of instruction-fetch requests in flight.
REQ-002 SHALL have port clk, input, 1 bit: the single clock.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port exc_valid, input, 1 bit: an exception is committed in MEM this cycle.
REQ-005 SHALL have ports exc_target (input, 32 bits) and int_valid (input, 1 bit): the exception/interrupt vector, and an interrupt taken this cycle.
REQ-006 SHALL have ports mispredict_valid (input, 1 bit) and mispredict_target (input, 32 bits): a MEM branch mispredict and its correct PC.
REQ-007 SHALL have port ds_stage, input, 2 bits: delay-slot location. 0 = not fetched, 1 = IF, 2 = ID, 3 = EX.
REQ-008 SHALL have port ds_fetch_done, input, 1 bit: IF accepted the delay-slot instruction this cycle.
REQ-009 SHALL have ports inst_req_valid and inst_req_ready (inputs, 1 bit each) and inst_resp_valid (input, 1 bit): the fetch request handshake and the fetch response.
REQ-010 SHALL have port redirect_ready, input, 1 bit: the PC unit accepts the redirect.
REQ-011 SHALL have outputs if_flush, id_flush and ex_flush, 1 bit each: pipeline stage flushes.
REQ-012 SHALL have outputs redirect_valid (1 bit) and redirect_pc (32 bits).
REQ-013 SHALL have outputs resp_discard (1 bit), req_block (1 bit) and busy (1 bit).

Function
REQ-014 SHALL keep an outstanding-request counter: +1 on req handshake (valid&&ready), -1 on inst_resp_valid; both in one cycle leaves it unchanged.
REQ-015 SHALL assert req_block when outstanding==MAX_OUTSTANDING or state is DRAIN.
REQ-016 SHALL implement the FSM states IDLE, WAIT_DS, DRAIN and REDIRECT; busy = (state!=IDLE).
REQ-017 SHALL resolve same-cycle events by priority exception > interrupt > mispredict, in every state.
REQ-018 SHALL, on an exception or interrupt, assert if/id/ex_flush combinationally in that cycle.
REQ-019 SHALL, on an exception or interrupt, latch target=exc_target and discard_cnt=outstanding-after-this-cycle's-update, then go to DRAIN if discard_cnt>0, else REDIRECT.
REQ-020 SHALL, on a mispredict with ds_stage=0, latch the target and enter WAIT_DS with no flush.
REQ-021 SHALL, in WAIT_DS, on ds_fetch_done latch discard_cnt=outstanding after update and go to DRAIN/REDIRECT as in REQ-019.
REQ-022 SHALL, on a mispredict with ds_stage!=0, flush only stages younger than the delay slot, same cycle.
REQ-023 SHALL use these flushes for REQ-022: ds_stage=1 gives no stage flush; ds_stage=2 gives if_flush; ds_stage=3 gives if_flush+id_flush. It then proceeds as REQ-019.
REQ-024 SHALL, in DRAIN, drive resp_discard=inst_resp_valid and decrement discard_cnt per response; at 0 it goes to REDIRECT.
REQ-025 SHALL, in REDIRECT, hold redirect_valid=1 and redirect_pc stable until redirect_ready, then go to IDLE.
REQ-026 SHALL, on an exception/interrupt arriving in WAIT_DS, DRAIN or REDIRECT, overwrite the target, re-flush and recompute discard_cnt.
REQ-027 SHALL ignore a mispredict arriving outside IDLE.
REQ-028 SHALL keep resp_discard=0 outside DRAIN.

Reset
REQ-029 SHALL, on rst, set state=IDLE, counters=0, redirect_pc=0, and all 1-bit outputs=0; rst applied mid-operation abandons the redirect.
REQ-030 SHALL keep outputs at reset values for the cycle rst is high, and SHALL ignore all event inputs during that cycle.

Structure
REQ-031 SHALL take the FSM state encoding, the 32-bit address width and the ds_stage encodings from the shared package cpu_pkg.
REQ-032 SHALL implement the outstanding counter (REQ-014/015) as sub-module fetch_req_counter, parameterised by MAX_OUTSTANDING, width clog2(MAX_OUTSTANDING+1).

Verification
REQ-033 SHALL cover: 2 outstanding, exc_valid with exc_target=0xBFC00380 -> one-cycle all-flush, 2 resp_discard pulses, then redirect_pc=0xBFC00380 until ready.
REQ-034 SHALL cover: mispredict, ds_stage=0, target 0x80001000 -> WAIT_DS with no flush; ds_fetch_done with 1 outstanding -> 1 discard, redirect 0x80001000.
REQ-035 SHALL cover: mispredict and int_valid in the same cycle -> interrupt wins, all flushes, redirect_pc=exc_target.
REQ-036 SHALL cover: exception while in REDIRECT for a mispredict, redirect_ready=0 -> redirect_pc switches to exc_target next cycle.
REQ-037 SHALL cover: 3 handshakes with no response -> req_block=1; a simultaneous request and response at count 3 -> count stays 3.
REQ-038 SHALL cover: rst asserted in DRAIN -> next cycle IDLE, busy=0, resp_discard=0 despite inst_resp_valid=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU front-end types used by the redirect controller.
// Holds the address width, the redirect FSM state encoding, the delay-slot
// location encoding and a helper that picks the state after a target latch.
package cpu_pkg;

  localparam int ADDR_W = 32;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_DS  = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_REDIRECT = 2'd3
  } redirect_state_e;

  // Where the branch delay-slot instruction currently sits.
  typedef enum logic [1:0] {
    DS_NONE = 2'd0,
    DS_IF   = 2'd1,
    DS_ID   = 2'd2,
    DS_EX   = 2'd3
  } ds_stage_e;

  // Stale fetches still in flight must be swallowed before the PC moves.
  function automatic redirect_state_e after_latch(input logic pending);
    return pending ? ST_DRAIN : ST_REDIRECT;
  endfunction

endpackage

// File: rtl/redirect_ctrl_if.sv
// redirect_ctrl_if: groups the fetch handshake and the PC redirect handshake.
//   inst_req_valid/inst_req_ready : fetch request handshake
//   inst_resp_valid               : fetch response returned
//   resp_discard                  : response must be thrown away
//   req_block                     : new fetch requests must not be issued
//   redirect_valid/redirect_pc    : redirect offered to the PC unit
//   redirect_ready                : PC unit accepts the redirect
// master = redirect controller, slave = fetch/PC side.
interface redirect_ctrl_if;
  import cpu_pkg::*;

  logic  inst_req_valid;
  logic  inst_req_ready;
  logic  inst_resp_valid;
  logic  resp_discard;
  logic  req_block;
  logic  redirect_valid;
  addr_t redirect_pc;
  logic  redirect_ready;

  modport master (
    input  inst_req_valid, inst_req_ready, inst_resp_valid, redirect_ready,
    output resp_discard, req_block, redirect_valid, redirect_pc
  );

  modport slave (
    output inst_req_valid, inst_req_ready, inst_resp_valid, redirect_ready,
    input  resp_discard, req_block, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/fetch_req_counter.sv
// fetch_req_counter: tracks instruction-fetch requests in flight.
//   clk, rst     : clock, synchronous active-high reset
//   req_fire     : request handshake completed this cycle
//   resp_valid   : response returned this cycle
//   count_next   : outstanding count after this cycle's update
//   at_max       : outstanding count (registered) equals MAX_OUTSTANDING
module fetch_req_counter #(
  parameter int MAX_OUTSTANDING = 3,
  parameter int CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_fire,
  input  logic          resp_valid,
  output logic [CW-1:0] count_next,
  output logic          at_max
);

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  logic [CW-1:0] count;

  // A request and a response together cancel; the bounds guard against
  // wrapping if the neighbours misbehave.
  always_comb begin
    count_next = count;
    if (req_fire && !resp_valid && count != MAX_CNT) begin
      count_next = count + CW'(1);
    end else if (resp_valid && !req_fire && count != '0) begin
      count_next = count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

  assign at_max = (count == MAX_CNT);

endmodule

// File: rtl/redirect_ctrl.sv
// redirect_ctrl: steers the front end after exceptions, interrupts and
// branch mispredicts. Flushes stages, waits for the delay slot if needed,
// discards fetch responses already in flight, then offers the new PC.
//   clk, rst                             : clock, synchronous active-high reset
//   exc_valid, int_valid, exc_target     : exception / interrupt and vector
//   mispredict_valid, mispredict_target  : MEM mispredict and correct PC
//   ds_stage, ds_fetch_done              : delay-slot location / IF accepted it
//   bus                                  : fetch + redirect handshakes
//   if_flush, id_flush, ex_flush         : stage flushes
//   busy                                 : FSM not idle
module redirect_ctrl
  import cpu_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   exc_valid,
  input  addr_t                  exc_target,
  input  logic                   int_valid,
  input  logic                   mispredict_valid,
  input  addr_t                  mispredict_target,
  input  logic [1:0]             ds_stage,
  input  logic                   ds_fetch_done,
  redirect_ctrl_if.master        bus,
  output logic                   if_flush,
  output logic                   id_flush,
  output logic                   ex_flush,
  output logic                   busy
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  redirect_state_e state_q, state_n;
  addr_t           target_q, target_n;
  logic [CW-1:0]   discard_q, discard_n;
  logic [CW-1:0]   count_next;
  logic            at_max;
  logic            trap;
  ds_stage_e       ds;

  fetch_req_counter #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CW              (CW)
  ) u_counter (
    .clk        (clk),
    .rst        (rst),
    .req_fire   (bus.inst_req_valid && bus.inst_req_ready),
    .resp_valid (bus.inst_resp_valid),
    .count_next (count_next),
    .at_max     (at_max)
  );

  // Exception and interrupt share the vector, so they collapse into one event.
  assign trap = exc_valid || int_valid;
  assign ds   = ds_stage_e'(ds_stage);

  // Next-state and flush decode. While rst is high everything stays at its
  // reset value and the event inputs are ignored.
  always_comb begin
    state_n   = state_q;
    target_n  = target_q;
    discard_n = discard_q;
    if_flush  = 1'b0;
    id_flush  = 1'b0;
    ex_flush  = 1'b0;
    if (!rst) begin
      if (trap) begin
        if_flush  = 1'b1;
        id_flush  = 1'b1;
        ex_flush  = 1'b1;
        target_n  = exc_target;
        discard_n = count_next;
        state_n   = after_latch(count_next != '0);
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (mispredict_valid) begin
              target_n = mispredict_target;
              if (ds == DS_NONE) begin
                state_n = ST_WAIT_DS;
              end else begin
                // Only stages younger than the delay slot are flushed.
                if_flush  = (ds == DS_ID) || (ds == DS_EX);
                id_flush  = (ds == DS_EX);
                discard_n = count_next;
                state_n   = after_latch(count_next != '0);
              end
            end
          end
          ST_WAIT_DS: begin
            if (ds_fetch_done) begin
              discard_n = count_next;
              state_n   = after_latch(count_next != '0);
            end
          end
          ST_DRAIN: begin
            if (bus.inst_resp_valid && discard_q != '0) begin
              discard_n = discard_q - CW'(1);
              if (discard_q == CW'(1)) begin
                state_n = ST_REDIRECT;
              end
            end
          end
          ST_REDIRECT: begin
            if (bus.redirect_ready) begin
              state_n = ST_IDLE;
            end
          end
          default: state_n = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      target_q  <= '0;
      discard_q <= '0;
    end else begin
      state_q   <= state_n;
      target_q  <= target_n;
      discard_q <= discard_n;
    end
  end

  // Discard is tied to DRAIN even if a new trap restarts the drain this cycle.
  always_comb begin
    bus.resp_discard   = !rst && (state_q == ST_DRAIN) && bus.inst_resp_valid;
    bus.req_block      = !rst && (at_max || state_q == ST_DRAIN);
    bus.redirect_valid = !rst && (state_q == ST_REDIRECT);
    bus.redirect_pc    = rst ? '0 : target_q;
    busy               = !rst && (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_redirect_ctrl.sv
// tb_redirect_ctrl: directed self-checking bench for redirect_ctrl.
module tb_redirect_ctrl;
  import cpu_pkg::*;

  logic       clk;
  logic       rst;
  logic       exc_valid;
  addr_t      exc_target;
  logic       int_valid;
  logic       mispredict_valid;
  addr_t      mispredict_target;
  logic [1:0] ds_stage;
  logic       ds_fetch_done;
  logic       if_flush, id_flush, ex_flush, busy;

  int tests_run    = 0;
  int tests_failed = 0;

  redirect_ctrl_if bus ();

  redirect_ctrl #(.MAX_OUTSTANDING(3)) dut (
    .clk               (clk),
    .rst               (rst),
    .exc_valid         (exc_valid),
    .exc_target        (exc_target),
    .int_valid         (int_valid),
    .mispredict_valid  (mispredict_valid),
    .mispredict_target (mispredict_target),
    .ds_stage          (ds_stage),
    .ds_fetch_done     (ds_fetch_done),
    .bus               (bus.master),
    .if_flush          (if_flush),
    .id_flush          (id_flush),
    .ex_flush          (ex_flush),
    .busy              (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Returns every event/handshake input to its quiet value.
  task automatic applyStimulus();
    exc_valid           = 1'b0;
    exc_target          = '0;
    int_valid           = 1'b0;
    mispredict_valid    = 1'b0;
    mispredict_target   = '0;
    ds_stage            = 2'd0;
    ds_fetch_done       = 1'b0;
    bus.inst_req_valid  = 1'b0;
    bus.inst_req_ready  = 1'b0;
    bus.inst_resp_valid = 1'b0;
    bus.redirect_ready  = 1'b0;
  endtask

  // Advances one clock and lands 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Completes n fetch request handshakes with no response.
  task automatic issueRequests(input int n);
    bus.inst_req_valid = 1'b1;
    bus.inst_req_ready = 1'b1;
    for (int i = 0; i < n; i++) tick();
    bus.inst_req_valid = 1'b0;
    bus.inst_req_ready = 1'b0;
  endtask

  function automatic logic [31:0] flushes();
    return {29'd0, if_flush, id_flush, ex_flush};
  endfunction

  initial begin
    applyStimulus();
    rst        = 1'b1;
    exc_valid  = 1'b1;
    exc_target = 32'h1234_5678;
    #2;
    checkOutput("rst_flush_ignored", flushes(), 32'h0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_redirect_pc", bus.redirect_pc, 32'h0);
    checkOutput("rst_req_block", {31'd0, bus.req_block}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    applyStimulus();
    #1;
    checkOutput("post_rst_idle", {31'd0, busy}, 32'd0);
    checkOutput("post_rst_redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);

    // Exception with two fetches outstanding.
    issueRequests(2);
    checkOutput("a_req_block_at2", {31'd0, bus.req_block}, 32'd0);
    exc_valid  = 1'b1;
    exc_target = 32'hBFC0_0380;
    #1;
    checkOutput("a_all_flush", flushes(), 32'h7);
    tick();
    applyStimulus();
    #1;
    checkOutput("a_flush_one_cycle", flushes(), 32'h0);
    checkOutput("a_drain_busy", {31'd0, busy}, 32'd1);
    checkOutput("a_drain_req_block", {31'd0, bus.req_block}, 32'd1);
    checkOutput("a_no_resp_no_discard", {31'd0, bus.resp_discard}, 32'd0);
    bus.inst_resp_valid = 1'b1;
    #1;
    checkOutput("a_discard_1", {31'd0, bus.resp_discard}, 32'd1);
    tick();
    checkOutput("a_discard_2", {31'd0, bus.resp_discard}, 32'd1);
    checkOutput("a_still_draining", {31'd0, bus.redirect_valid}, 32'd0);
    tick();
    bus.inst_resp_valid = 1'b0;
    #1;
    checkOutput("a_redirect_valid", {31'd0, bus.redirect_valid}, 32'd1);
    checkOutput("a_redirect_pc", bus.redirect_pc, 32'hBFC0_0380);
    checkOutput("a_req_unblocked", {31'd0, bus.req_block}, 32'd0);
    tick();
    checkOutput("a_redirect_held", bus.redirect_pc, 32'hBFC0_0380);
    checkOutput("a_redirect_valid_held", {31'd0, bus.redirect_valid}, 32'd1);
    bus.redirect_ready = 1'b1;
    tick();
    bus.redirect_ready = 1'b0;
    checkOutput("a_back_idle", {31'd0, busy}, 32'd0);

    // Mispredict with the delay slot not yet fetched.
    issueRequests(1);
    mispredict_valid  = 1'b1;
    mispredict_target = 32'h8000_1000;
    ds_stage          = 2'd0;
    #1;
    checkOutput("b_no_flush", flushes(), 32'h0);
    tick();
    applyStimulus();
    #1;
    checkOutput("b_wait_ds_busy", {31'd0, busy}, 32'd1);
    checkOutput("b_wait_ds_no_redirect", {31'd0, bus.redirect_valid}, 32'd0);
    checkOutput("b_wait_ds_no_block", {31'd0, bus.req_block}, 32'd0);
    ds_fetch_done = 1'b1;
    tick();
    ds_fetch_done = 1'b0;
    #1;
    checkOutput("b_drain_block", {31'd0, bus.req_block}, 32'd1);
    bus.inst_resp_valid = 1'b1;
    #1;
    checkOutput("b_discard", {31'd0, bus.resp_discard}, 32'd1);
    tick();
    bus.inst_resp_valid = 1'b0;
    #1;
    checkOutput("b_redirect_valid", {31'd0, bus.redirect_valid}, 32'd1);
    checkOutput("b_redirect_pc", bus.redirect_pc, 32'h8000_1000);
    bus.redirect_ready = 1'b1;
    tick();
    bus.redirect_ready = 1'b0;

    // Interrupt and mispredict together: interrupt wins.
    mispredict_valid  = 1'b1;
    mispredict_target = 32'h8000_2000;
    ds_stage          = 2'd2;
    int_valid         = 1'b1;
    exc_target        = 32'h8000_0180;
    #1;
    checkOutput("c_all_flush", flushes(), 32'h7);
    tick();
    applyStimulus();
    #1;
    checkOutput("c_redirect_valid", {31'd0, bus.redirect_valid}, 32'd1);
    checkOutput("c_redirect_pc", bus.redirect_pc, 32'h8000_0180);
    bus.redirect_ready = 1'b1;
    tick();
    bus.redirect_ready = 1'b0;

    // Mispredict with delay slot in EX, then exception during REDIRECT.
    mispredict_valid  = 1'b1;
    mispredict_target = 32'h8000_3000;
    ds_stage          = 2'd3;
    #1;
    checkOutput("d_flush_if_id", flushes(), 32'h6);
    tick();
    applyStimulus();
    #1;
    checkOutput("d_redirect_pc", bus.redirect_pc, 32'h8000_3000);
    exc_valid  = 1'b1;
    exc_target = 32'hBFC0_0200;
    #1;
    checkOutput("d_reflush", flushes(), 32'h7);
    tick();
    applyStimulus();
    #1;
    checkOutput("d_redirect_pc_switched", bus.redirect_pc, 32'hBFC0_0200);
    checkOutput("d_redirect_valid", {31'd0, bus.redirect_valid}, 32'd1);
    bus.redirect_ready = 1'b1;
    tick();
    bus.redirect_ready = 1'b0;

    // Delay slot in IF / ID, and a mispredict ignored outside IDLE.
    mispredict_valid  = 1'b1;
    mispredict_target = 32'h8000_4000;
    ds_stage          = 2'd1;
    #1;
    checkOutput("e_ds_if_no_flush", flushes(), 32'h0);
    tick();
    mispredict_target = 32'h8000_5000;
    ds_stage          = 2'd2;
    #1;
    checkOutput("e_redirect_direct", {31'd0, bus.redirect_valid}, 32'd1);
    checkOutput("e_late_mispredict_no_flush", flushes(), 32'h0);
    tick();
    applyStimulus();
    #1;
    checkOutput("e_late_mispredict_ignored", bus.redirect_pc, 32'h8000_4000);
    bus.redirect_ready = 1'b1;
    tick();
    bus.redirect_ready = 1'b0;
    mispredict_valid  = 1'b1;
    mispredict_target = 32'h8000_6000;
    ds_stage          = 2'd2;
    #1;
    checkOutput("e_ds_id_flush_if", flushes(), 32'h4);
    tick();
    applyStimulus();
    bus.redirect_ready = 1'b1;
    tick();
    bus.redirect_ready = 1'b0;

    // Outstanding limit and simultaneous request/response at the limit.
    issueRequests(2);
    checkOutput("f_two_not_blocked", {31'd0, bus.req_block}, 32'd0);
    issueRequests(1);
    checkOutput("f_three_blocked", {31'd0, bus.req_block}, 32'd1);
    bus.inst_req_valid  = 1'b1;
    bus.inst_req_ready  = 1'b1;
    bus.inst_resp_valid = 1'b1;
    tick();
    bus.inst_req_valid  = 1'b0;
    bus.inst_req_ready  = 1'b0;
    checkOutput("f_stays_three", {31'd0, bus.req_block}, 32'd1);
    tick();
    bus.inst_resp_valid = 1'b0;
    checkOutput("f_down_to_two", {31'd0, bus.req_block}, 32'd0);

    // Reset while draining.
    exc_valid  = 1'b1;
    exc_target = 32'hBFC0_0380;
    tick();
    applyStimulus();
    bus.inst_resp_valid = 1'b1;
    #1;
    checkOutput("g_draining", {31'd0, bus.resp_discard}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("g_rst_gates_discard", {31'd0, bus.resp_discard}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("g_idle_busy", {31'd0, busy}, 32'd0);
    checkOutput("g_no_discard", {31'd0, bus.resp_discard}, 32'd0);
    checkOutput("g_no_redirect", {31'd0, bus.redirect_valid}, 32'd0);
    checkOutput("g_pc_cleared", bus.redirect_pc, 32'h0);
    applyStimulus();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
